// File: rtl/spi_master_byte.sv
// spi_master_byte: byte-oriented SPI mode-0 master.
// SCK is derived from clk by integer division; each byte (or each burst of
// bytes) is framed by active-low SSEL. All outputs come straight from flops.
//
// Optional feature macro: SPI_MASTER_BURST_EN
//   defined   - a byte offered on the final falling-edge cycle is accepted and
//               shifted back-to-back with SSEL held low.
//   undefined - every byte is framed individually (SETUP, SHIFT, HOLD, GAP).
//
// State table:
//   IDLE  | waiting for a byte, tx_ready high, SSEL high
//   SETUP | SSEL low, MOSI = bit7, waiting CS_SETUP cycles before first rise
//   SHIFT | SCK toggling every CLK_DIV cycles, 8 high phases per byte
//   HOLD  | SCK low, SSEL still low for CLK_DIV cycles after the final fall
//   GAP   | SSEL high, CS_GAP cycles before the next byte can be accepted
module spi_master_byte #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SSEL
);

`ifdef SPI_MASTER_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
    localparam int WAIT_W   = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    // A half-period spans DIV_LAST..0; after the final fall the falling-edge
    // cycle itself already counts as one low cycle, hence DIV_PRE.
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_PRE    = DIV_W'(CLK_DIV - 2);
    localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [2:0]         bit_q, bit_d;
    logic               last_q, last_d;
    logic [7:0]         tx_sh_q, tx_sh_d;
    logic [7:0]         rx_sh_q, rx_sh_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               sck_q, sck_d;
    logic               ssel_q, ssel_d;
    logic               tx_ready_q, tx_ready_d;
    logic               busy_q, busy_d;

    // State and datapath registers; reset aborts any byte in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            wait_q     <= '0;
            bit_q      <= 3'd0;
            last_q     <= 1'b0;
            tx_sh_q    <= 8'h00;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            wait_q     <= wait_d;
            bit_q      <= bit_d;
            last_q     <= last_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            ssel_q     <= ssel_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and next-output logic for the framing/shift sequencer.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        wait_d     = wait_q;
        bit_d      = bit_q;
        last_d     = 1'b0;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sck_d      = sck_q;
        ssel_d     = ssel_q;
        tx_ready_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ssel_d = 1'b1;
                sck_d  = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    tx_sh_d = tx_data;
                    ssel_d  = 1'b0;
                    wait_d  = SETUP_LAST;
                    state_d = ST_SETUP;
                end else begin
                    tx_ready_d = 1'b1;
                end
            end

            ST_SETUP: begin
                if (wait_q == '0) begin
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], MISO};
                    div_d   = DIV_LAST;
                    bit_d   = 3'd0;
                    state_d = ST_SHIFT;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            ST_SHIFT: begin
                if (last_q) begin
                    // Cycle right after the 8th fall: chain or close the frame.
                    div_d = DIV_PRE;
                    if (BURST_EN && tx_valid && tx_ready_q) begin
                        tx_sh_d = tx_data;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (div_q == '0) begin
                    div_d = DIV_LAST;
                    if (sck_q) begin
                        sck_d   = 1'b0;
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        if (bit_q == 3'd7) begin
                            rx_data_d  = rx_sh_q;
                            rx_valid_d = 1'b1;
                            last_d     = 1'b1;
                            tx_ready_d = BURST_EN;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        sck_d   = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], MISO};
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end

            ST_HOLD: begin
                sck_d = 1'b0;
                if (div_q == '0) begin
                    ssel_d  = 1'b1;
                    wait_d  = GAP_LAST;
                    state_d = ST_GAP;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end

            ST_GAP: begin
                if (wait_q == '0) begin
                    state_d    = ST_IDLE;
                    tx_ready_d = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ssel_d  = 1'b1;
                sck_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign SCK      = sck_q;
    assign MOSI     = tx_sh_q[7];
    assign SSEL     = ssel_q;

endmodule
